alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: CNTW, 16, width of retired-operation counter.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream ALU result valid this cycle.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 sum  input  32  ALU result.
REQ-008 zout  input  1  ALU zero flag.
REQ-009 nout  input  1  ALU negative flag (sum[31]).
REQ-010 rd  input  5  destination register number.
REQ-011 regwrite, memread, memwrite  input  1 each  control bits carried with the result.
REQ-012 branch  input  1  entry is a conditional branch.
REQ-013 bne  input  1  branch sense: 0 = taken on zero (beq), 1 = taken on non-zero (bne).
REQ-014 flush  input  1  discard all held entries and any same-cycle input.
REQ-015 out_valid  output  1  head entry valid.
REQ-016 out_ready  input  1  downstream accepts head entry.
REQ-017 out_sum  output  32; out_rd  output  5; out_regwrite, out_memread, out_memwrite  output  1 each: head entry fields.
REQ-018 out_taken  output  1  head entry branch resolution.
REQ-019 out_zflag, out_nflag  output  1 each  head entry flags.
REQ-020 stat_z, stat_n  output  1 each  flags of the most recently retired entry.
REQ-021 op_count  output  CNTW  number of retired entries, modulo 2^CNTW.

Function
REQ-022 Storage SHALL be a 2-entry FIFO (skid buffer); all outputs SHALL be driven from registers, with no combinational path from in_* to out_*.
REQ-023 in_ready SHALL be 1 when fewer than 2 entries are held, derived from registered occupancy only (no dependence on out_ready).
REQ-024 Push: in_valid & in_ready & ~flush captures sum, zout, nout, rd, control bits and taken at the clock edge.
REQ-025 taken SHALL be computed at push as branch & (bne ? ~zout : zout); taken SHALL be 0 when branch=0.
REQ-026 Pop: out_valid & out_ready & ~flush retires the head entry; the next entry becomes head on the following cycle.
REQ-027 Simultaneous push and pop with 1 entry held SHALL leave occupancy at 1, with the new entry as head on the next cycle.
REQ-028 When full, a same-cycle pop SHALL NOT enable a push (in_ready stays 0 that cycle).
REQ-029 Latency: an entry pushed into an empty stage SHALL appear with out_valid=1 on the next cycle.
REQ-030 Order SHALL be strictly FIFO; no entry SHALL be dropped or duplicated except by flush or reset.
REQ-031 Head outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-032 On each pop, stat_z/stat_n SHALL load the popped entry's flags and op_count SHALL increment by 1, wrapping from 2^CNTW-1 to 0.
REQ-033 Flush SHALL empty the FIFO at the next edge, suppress that cycle's push and pop, and leave stat_z, stat_n, op_count unchanged.
REQ-034 out_* data fields when out_valid=0 are don't-care for consumers; the implementation SHALL hold them at their last value.

Reset
REQ-035 Reset SHALL take priority over flush, push and pop.
REQ-036 After reset: occupancy 0, out_valid=0, in_ready=1, out_sum=0, out_rd=0, all out_* control, taken and flag outputs 0, stat_z=0, stat_n=0, op_count=0.
REQ-037 Reset asserted with entries held SHALL discard them with no pop counted.

Verification
REQ-038 Single pass: push sum=0x00000005, zout=0, rd=3, regwrite=1, out_ready=1 -> next cycle out_valid=1, out_sum=5, out_rd=3; following cycle op_count=1, stat_z=0.
REQ-039 Back-pressure: out_ready=0, push A=0x11 and B=0x22 on consecutive cycles -> in_ready=0 after the second push, a third input is not accepted, outputs hold A; then out_ready=1 -> A, B retire in order, op_count=2.
REQ-040 Branch: push branch=1, bne=0, zout=1 -> out_taken=1; push branch=1, bne=1, zout=1 -> out_taken=0; push branch=0, zout=1 -> out_taken=0.
REQ-041 Flush: 2 entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, op_count unchanged, flushed input never appears.
REQ-042 Wrap and reset: CNTW=4, retire 16 entries -> op_count=0; reset with 1 entry held and nout=1 -> all outputs per REQ-036, stat_n=0.

Source files
------------

// File: rtl/alu_result_stage.sv
// ALU result stage: a 2-entry skid FIFO between the ALU and the next pipeline
// stage. It resolves branches on entry, presents the head entry from
// registers, and keeps flags of the last retired result plus a retire count.
module alu_result_stage #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     sum,
  input  logic            zout,
  input  logic            nout,
  input  logic [4:0]      rd,
  input  logic            regwrite,
  input  logic            memread,
  input  logic            memwrite,
  input  logic            branch,
  input  logic            bne,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_sum,
  output logic [4:0]      out_rd,
  output logic            out_regwrite,
  output logic            out_memread,
  output logic            out_memwrite,
  output logic            out_taken,
  output logic            out_zflag,
  output logic            out_nflag,
  output logic            stat_z,
  output logic            stat_n,
  output logic [CNTW-1:0] op_count
);

  typedef struct packed {
    logic [31:0] sum;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        taken;
    logic        zflag;
    logic        nflag;
  } entry_t;

  // head drives the outputs directly; skid only holds the second entry
  entry_t     head;
  entry_t     skid;
  entry_t     incoming;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // Readiness and validity depend only on registered occupancy, so the
  // upstream handshake never sees a path through out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Build the entry to capture, resolving the branch at push time
  always_comb begin
    incoming          = '0;
    incoming.sum      = sum;
    incoming.rd       = rd;
    incoming.regwrite = regwrite;
    incoming.memread  = memread;
    incoming.memwrite = memwrite;
    incoming.taken    = branch & (bne ? ~zout : zout);
    incoming.zflag    = zout;
    incoming.nflag    = nout;
  end

  assign out_sum      = head.sum;
  assign out_rd       = head.rd;
  assign out_regwrite = head.regwrite;
  assign out_memread  = head.memread;
  assign out_memwrite = head.memwrite;
  assign out_taken    = head.taken;
  assign out_zflag    = head.zflag;
  assign out_nflag    = head.nflag;

  // FIFO occupancy, head/skid movement and retire statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= 2'd0;
      head     <= '0;
      skid     <= '0;
      stat_z   <= 1'b0;
      stat_n   <= 1'b0;
      op_count <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (pop) begin
        stat_z   <= head.zflag;
        stat_n   <= head.nflag;
        op_count <= op_count + CNTW'(1);
      end
      case (count)
        2'd0: begin
          if (push) begin
            head  <= incoming;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= incoming;
          end else if (push) begin
            skid  <= incoming;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head  <= skid;
            count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed vector table, handshake
// corner sequences and randomized traffic against a queue-based model.
module tb_alu_result_stage;

  localparam int CNTW = 4;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     sum;
  logic            zout;
  logic            nout;
  logic [4:0]      rd;
  logic            regwrite;
  logic            memread;
  logic            memwrite;
  logic            branch;
  logic            bne;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_sum;
  logic [4:0]      out_rd;
  logic            out_regwrite;
  logic            out_memread;
  logic            out_memwrite;
  logic            out_taken;
  logic            out_zflag;
  logic            out_nflag;
  logic            stat_z;
  logic            stat_n;
  logic [CNTW-1:0] op_count;

  alu_result_stage #(.CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .zout(zout), .nout(nout), .rd(rd), .regwrite(regwrite),
    .memread(memread), .memwrite(memwrite), .branch(branch), .bne(bne),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_rd(out_rd), .out_regwrite(out_regwrite),
    .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_taken(out_taken), .out_zflag(out_zflag), .out_nflag(out_nflag),
    .stat_z(stat_z), .stat_n(stat_n), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] sum;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        taken;
    logic        zflag;
    logic        nflag;
  } ent_t;

  typedef struct {
    logic        in_valid;
    logic [31:0] sum;
    logic        zout;
    logic [4:0]  rd;
    logic        regwrite;
    logic        branch;
    logic        bne;
    logic        out_ready;
    logic        exp_valid;
    logic [31:0] exp_sum;
    logic [4:0]  exp_rd;
    logic        exp_taken;
    logic [3:0]  exp_count;
    logic        exp_stat_z;
  } vec_t;

  int checks = 0;
  int errors = 0;

  ent_t       mq[$];
  logic       m_stat_z;
  logic       m_stat_n;
  logic [3:0] m_count;

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(logic v, logic [31:0] s, logic z, logic n,
                               logic [4:0] r, logic rw, logic mr, logic mw,
                               logic br, logic bn, logic fl, logic ordy);
    in_valid = v; sum = s; zout = z; nout = n; rd = r;
    regwrite = rw; memread = mr; memwrite = mw;
    branch = br; bne = bn; flush = fl; out_ready = ordy;
  endtask

  // Reference behaviour: queue of at most two entries, one clock step
  task automatic modelStep();
    ent_t e;
    bit   can_push;
    bit   do_pop;
    if (reset) begin
      mq.delete();
      m_stat_z = 1'b0;
      m_stat_n = 1'b0;
      m_count  = 4'd0;
    end else if (flush) begin
      mq.delete();
    end else begin
      can_push = (mq.size() < 2);
      do_pop   = (mq.size() > 0) && out_ready;
      if (do_pop) begin
        e = mq.pop_front();
        m_stat_z = e.zflag;
        m_stat_n = e.nflag;
        m_count  = m_count + 4'd1;
      end
      if (in_valid && can_push) begin
        e.sum      = sum;
        e.rd       = rd;
        e.regwrite = regwrite;
        e.memread  = memread;
        e.memwrite = memwrite;
        e.taken    = branch ? (bne ? !zout : zout) : 1'b0;
        e.zflag    = zout;
        e.nflag    = nout;
        mq.push_back(e);
      end
    end
  endtask

  task automatic checkModel();
    ent_t act;
    checkOutput("valid", 64'(out_valid), 64'(mq.size() > 0));
    checkOutput("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    checkOutput("op_count", 64'(op_count), 64'(m_count));
    checkOutput("stat", 64'({stat_z, stat_n}), 64'({m_stat_z, m_stat_n}));
    if (mq.size() > 0) begin
      act = {out_sum, out_rd, out_regwrite, out_memread, out_memwrite,
             out_taken, out_zflag, out_nflag};
      checkOutput("head", 64'(act), 64'(mq[0]));
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic checkResetState(string name);
    checkOutput(name,
      64'({out_valid, in_ready, out_sum, out_rd, out_regwrite, out_memread,
           out_memwrite, out_taken, out_zflag, out_nflag, stat_z, stat_n,
           op_count}),
      64'({1'b0, 1'b1, 32'd0, 5'd0, 3'b000, 1'b0, 2'b00, 2'b00, 4'd0}));
  endtask

  vec_t       vecs[6];
  logic [3:0] saved_count;
  int unsigned r;

  initial begin
    vecs[0] = '{1'b1, 32'h5, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1,
                1'b1, 32'h5, 5'd3, 1'b0, 4'd0, 1'b0};
    vecs[1] = '{1'b0, 32'h9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b0, 32'h5, 5'd3, 1'b0, 4'd1, 1'b0};
    vecs[2] = '{1'b1, 32'h0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b1, 32'h0, 5'd1, 1'b1, 4'd1, 1'b0};
    vecs[3] = '{1'b1, 32'h0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b1,
                1'b1, 32'h0, 5'd2, 1'b0, 4'd2, 1'b1};
    vecs[4] = '{1'b1, 32'h7, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1,
                1'b1, 32'h7, 5'd4, 1'b0, 4'd3, 1'b1};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b0, 32'h7, 5'd4, 1'b0, 4'd4, 1'b1};

    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkResetState("reset_state");
    reset = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].in_valid, vecs[i].sum, vecs[i].zout, 1'b0,
                    vecs[i].rd, vecs[i].regwrite, 1'b0, 1'b0,
                    vecs[i].branch, vecs[i].bne, 1'b0, vecs[i].out_ready);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_sum", i), 64'(out_sum), 64'(vecs[i].exp_sum));
      checkOutput($sformatf("vec%0d_rd", i), 64'(out_rd), 64'(vecs[i].exp_rd));
      checkOutput($sformatf("vec%0d_taken", i), 64'(out_taken), 64'(vecs[i].exp_taken));
      checkOutput($sformatf("vec%0d_count", i), 64'(op_count), 64'(vecs[i].exp_count));
      checkOutput($sformatf("vec%0d_stat_z", i), 64'(stat_z), 64'(vecs[i].exp_stat_z));
    end

    $display("[TB] back-pressure sequence");
    applyStimulus(1, 32'h11, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 32'h22, 0, 0, 5'd6, 1, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("bp_full_ready", 64'(in_ready), 64'd0);
    checkOutput("bp_head_a", 64'(out_sum), 64'h11);
    applyStimulus(1, 32'h33, 0, 0, 5'd7, 1, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("bp_hold_a", 64'(out_sum), 64'h11);
    applyStimulus(1, 32'h44, 0, 0, 5'd8, 1, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("bp_head_b", 64'(out_sum), 64'h22);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("bp_drained", 64'(out_valid), 64'd0);
    checkOutput("bp_count", 64'(op_count), 64'd6);

    $display("[TB] flush sequence");
    applyStimulus(1, 32'h55, 1, 0, 5'd9, 1, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 32'h66, 0, 1, 5'd10, 1, 0, 0, 0, 0, 0, 0);
    tick();
    saved_count = m_count;
    applyStimulus(1, 32'h77, 0, 0, 5'd11, 1, 0, 0, 0, 0, 1, 1);
    tick();
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_ready", 64'(in_ready), 64'd1);
    checkOutput("flush_count", 64'(op_count), 64'(saved_count));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("flush_no_ghost", 64'(out_valid), 64'd0);

    $display("[TB] counter wrap sequence");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 32'(i + 100), 0, 0, 5'(i), 1, 0, 0, 0, 0, 0, 1);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("wrap_count", 64'(op_count), 64'd0);

    $display("[TB] reset with held entry");
    applyStimulus(1, 32'h8000_0001, 0, 1, 5'd12, 1, 1, 1, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("pre_reset_stat_n", 64'(stat_n), 64'd1);
    applyStimulus(1, 32'h8000_0002, 0, 1, 5'd13, 1, 0, 1, 1, 1, 0, 0);
    tick();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkResetState("reset_held");
    reset = 1'b0;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      reset = ($urandom_range(0, 99) == 0);
      applyStimulus($urandom_range(0, 2) != 0,
                    ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom),
                    r[0], r[1], r[6:2], r[7], r[8], r[9], r[10], r[11],
                    $urandom_range(0, 15) == 0, r[12] | r[13]);
      tick();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
